reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_if.sv | 52 +++++
 rtl/reorder_buffer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Bundle of the reorder buffer's issue, operand, CDB, commit and flush signals.
// master = decoder/RF/CDB side, slave = the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int unsigned ROB_ID_WIDTH = 4
);
    logic                    issue_valid;
    logic                    issue_ready;
    logic [4:0]              issue_rd;
    logic                    issue_is_br;
    logic                    issue_pred_taken;
    logic [31:0]             issue_alt_pc;
    logic [ROB_ID_WIDTH-1:0] rob2rf_tag;

    logic [ROB_ID_WIDTH-1:0] rf2rob_lab1;
    logic [ROB_ID_WIDTH-1:0] rf2rob_lab2;
    logic [31:0]             rf2rob_val1;
    logic [31:0]             rf2rob_val2;
    logic [31:0]             op1_val;
    logic [31:0]             op2_val;
    logic [ROB_ID_WIDTH-1:0] op1_tag;
    logic [ROB_ID_WIDTH-1:0] op2_tag;

    logic                    cdb_en;
    logic [ROB_ID_WIDTH-1:0] cdb_tag;
    logic [31:0]             cdb_val;
    logic                    cdb_taken;

    logic                    commit_en;
    logic [4:0]              rob2rf_commit_rd;
    logic [31:0]             rob2rf_commit_res;
    logic [ROB_ID_WIDTH-1:0] rob2rf_commit_lab;
    logic                    flush;
    logic [31:0]             flush_pc;

    modport master (
        output issue_valid, issue_rd, issue_is_br, issue_pred_taken, issue_alt_pc,
        output rf2rob_lab1, rf2rob_lab2, rf2rob_val1, rf2rob_val2,
        output cdb_en, cdb_tag, cdb_val, cdb_taken,
        input  issue_ready, rob2rf_tag, op1_val, op2_val, op1_tag, op2_tag,
        input  commit_en, rob2rf_commit_rd, rob2rf_commit_res, rob2rf_commit_lab,
        input  flush, flush_pc
    );

    modport slave (
        input  issue_valid, issue_rd, issue_is_br, issue_pred_taken, issue_alt_pc,
        input  rf2rob_lab1, rf2rob_lab2, rf2rob_val1, rf2rob_val2,
        input  cdb_en, cdb_tag, cdb_val, cdb_taken,
        output issue_ready, rob2rf_tag, op1_val, op2_val, op1_tag, op2_tag,
        output commit_en, rob2rf_commit_rd, rob2rf_commit_res, rob2rf_commit_lab,
        output flush, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order commit, operand lookup by tag, flush on branch mispredict.
// Define ROB_BYPASS_EN to forward the same-cycle CDB result into operand resolution.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE     = 8,
    parameter int unsigned ROB_ID_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave rob
);
    localparam int unsigned IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(ROB_SIZE);
    localparam logic [ROB_ID_WIDTH-1:0] MAX_TAG = ROB_ID_WIDTH'(ROB_SIZE);

    logic [IDX_W-1:0]        head_q, tail_q;
    logic [IDX_W:0]          count_q;
    logic [ROB_SIZE-1:0]     busy_q, ready_q;
    logic [ROB_SIZE-1:0]     is_br_q, pred_taken_q, taken_q;
    logic [4:0]              rd_q     [ROB_SIZE];
    logic [31:0]             value_q  [ROB_SIZE];
    logic [31:0]             alt_pc_q [ROB_SIZE];

    logic                    commit_en_q, flush_q;
    logic [31:0]             flush_pc_q, commit_res_q;
    logic [4:0]              commit_rd_q;
    logic [ROB_ID_WIDTH-1:0] commit_lab_q;

    logic                    issue_ready;
    logic                    do_alloc, do_cdb, do_commit, mispredict;
    logic [IDX_W-1:0]        cdb_idx, idx1, idx2;
    logic                    byp1, byp2;

    assign issue_ready = (count_q < FULL_CNT) && !flush_q;
    assign cdb_idx     = IDX_W'(rob.cdb_tag - ROB_ID_WIDTH'(1));

    assign do_alloc  = rob.issue_valid && issue_ready && rdy_in;
    // Tag 0 and tags beyond the buffer never name an entry.
    assign do_cdb    = rob.cdb_en && rdy_in && !flush_q && (rob.cdb_tag != '0) &&
                       (rob.cdb_tag <= MAX_TAG) && busy_q[cdb_idx];
    assign do_commit = busy_q[head_q] && ready_q[head_q] && rdy_in && !flush_q;
    assign mispredict = is_br_q[head_q] && (taken_q[head_q] != pred_taken_q[head_q]);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            ready_q      <= '0;
            commit_en_q  <= 1'b0;
            flush_q      <= 1'b0;
            flush_pc_q   <= '0;
            commit_rd_q  <= '0;
            commit_res_q <= '0;
            commit_lab_q <= '0;
        end else begin
            // Pulses are recomputed every edge so they never repeat while frozen.
            commit_en_q <= do_commit;
            flush_q     <= do_commit && mispredict;
            if (flush_q) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                busy_q  <= '0;
                ready_q <= '0;
            end else if (rdy_in) begin
                if (do_alloc) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    tail_q          <= tail_q + IDX_W'(1);
                end
                if (do_cdb) begin
                    ready_q[cdb_idx] <= 1'b1;
                end
                if (do_commit) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + IDX_W'(1);
                    commit_rd_q    <= rd_q[head_q];
                    commit_res_q   <= value_q[head_q];
                    commit_lab_q   <= ROB_ID_WIDTH'(head_q) + ROB_ID_WIDTH'(1);
                    if (mispredict) begin
                        flush_pc_q <= alt_pc_q[head_q];
                    end
                end
                if (do_alloc && !do_commit) begin
                    count_q <= count_q + (IDX_W + 1)'(1);
                end else if (!do_alloc && do_commit) begin
                    count_q <= count_q - (IDX_W + 1)'(1);
                end
            end
        end
    end

    // Payload needs no reset: it is only observed behind busy/ready.
    always_ff @(posedge clk) begin
        if (rdy_in && !flush_q) begin
            if (do_alloc) begin
                rd_q[tail_q]         <= rob.issue_rd;
                is_br_q[tail_q]      <= rob.issue_is_br;
                pred_taken_q[tail_q] <= rob.issue_pred_taken;
                alt_pc_q[tail_q]     <= rob.issue_alt_pc;
            end
            if (do_cdb) begin
                value_q[cdb_idx] <= rob.cdb_val;
                taken_q[cdb_idx] <= rob.cdb_taken;
            end
        end
    end

`ifdef ROB_BYPASS_EN
    assign byp1 = rob.cdb_en && (rob.cdb_tag == rob.rf2rob_lab1);
    assign byp2 = rob.cdb_en && (rob.cdb_tag == rob.rf2rob_lab2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    function automatic logic [ROB_ID_WIDTH+31:0] resolve(
        input logic [ROB_ID_WIDTH-1:0] lab,
        input logic [31:0]             rf_val,
        input logic                    byp,
        input logic [31:0]             byp_val,
        input logic                    ent_ready,
        input logic [31:0]             ent_val
    );
        if (lab == '0) return {rf_val, {ROB_ID_WIDTH{1'b0}}};
        if (byp)       return {byp_val, {ROB_ID_WIDTH{1'b0}}};
        if (ent_ready) return {ent_val, {ROB_ID_WIDTH{1'b0}}};
        return {32'd0, lab};
    endfunction

    assign idx1 = IDX_W'(rob.rf2rob_lab1 - ROB_ID_WIDTH'(1));
    assign idx2 = IDX_W'(rob.rf2rob_lab2 - ROB_ID_WIDTH'(1));

    assign {rob.op1_val, rob.op1_tag} = resolve(rob.rf2rob_lab1, rob.rf2rob_val1, byp1,
        rob.cdb_val, (rob.rf2rob_lab1 <= MAX_TAG) && ready_q[idx1], value_q[idx1]);
    assign {rob.op2_val, rob.op2_tag} = resolve(rob.rf2rob_lab2, rob.rf2rob_val2, byp2,
        rob.cdb_val, (rob.rf2rob_lab2 <= MAX_TAG) && ready_q[idx2], value_q[idx2]);

    assign rob.issue_ready       = issue_ready;
    assign rob.rob2rf_tag        = ROB_ID_WIDTH'(tail_q) + ROB_ID_WIDTH'(1);
    assign rob.commit_en         = commit_en_q;
    assign rob.rob2rf_commit_rd  = commit_rd_q;
    assign rob.rob2rf_commit_res = commit_res_q;
    assign rob.rob2rf_commit_lab = commit_lab_q;
    assign rob.flush             = flush_q;
    assign rob.flush_pc          = flush_pc_q;
endmodule
